// File: rtl/mix_columns_engine_if.sv
// Block handshake bundle for mix_columns_engine: input state/mode with valid/ready, result with valid/ready.
// Latency: n/a (wires only). Backpressure: carried by in_ready/out_ready.
// master drives the engine, slave is the engine itself.
interface mix_columns_engine_if;
   logic         in_valid;
   logic         in_ready;
   logic         mode;
   logic [127:0] state_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] state_out;
   logic         busy;

   modport master (
      output in_valid, mode, state_in, out_ready,
      input  in_ready, out_valid, state_out, busy
   );

   modport slave (
      input  in_valid, mode, state_in, out_ready,
      output in_ready, out_valid, state_out, busy
   );
endinterface

// File: rtl/mix_columns_engine.sv
// Purpose: AES (Inv)MixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock; MIXCOL_FWD_EN adds forward mode.
// Latency: out_valid after 4/COLS_PER_CYCLE RUN cycles following the input handshake.
// Backpressure: result held in DONE until out_ready; no new block accepted outside IDLE.
module mix_columns_engine #(
   parameter int COLS_PER_CYCLE = 1
) (
   input logic              clk,
   input logic              rst,
   mix_columns_engine_if.slave bus
);

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   // cnt is always a multiple of COLS_PER_CYCLE, so lanes are cnt|l and a column is hit when its masked index equals cnt
   localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);
   localparam logic [1:0] MASK = ~(2'(COLS_PER_CYCLE - 1));

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state, state_nxt;
   logic [127:0] work, work_nxt;
   logic [1:0]   cnt;
   logic         in_ready, out_valid, busy;
   logic [31:0]  lane_in  [COLS_PER_CYCLE];
   logic [31:0]  lane_out [COLS_PER_CYCLE];
`ifdef MIXCOL_FWD_EN
   logic         mode_q;
`endif

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] col_of(input logic [127:0] w, input logic [1:0] idx);
      logic [31:0] c;
      case (idx)
         2'd0:    c = w[127:96];
         2'd1:    c = w[95:64];
         2'd2:    c = w[63:32];
         default: c = w[31:0];
      endcase
      return c;
   endfunction

   function automatic logic [31:0] inv_col(input logic [31:0] col);
      logic [7:0] a  [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      logic [31:0] r;
      for (int j = 0; j < 4; j++) begin
         a[j]  = col[31 - 8*j -: 8];
         x2    = xt(a[j]);
         x4    = xt(x2);
         x8    = xt(x4);
         m9[j] = x8 ^ a[j];
         mb[j] = x8 ^ x2 ^ a[j];
         md[j] = x8 ^ x4 ^ a[j];
         me[j] = x8 ^ x4 ^ x2;
      end
      for (int i = 0; i < 4; i++) begin
         r[31 - 8*i -: 8] = me[i] ^ mb[(i + 1) % 4] ^ md[(i + 2) % 4] ^ m9[(i + 3) % 4];
      end
      return r;
   endfunction

`ifdef MIXCOL_FWD_EN
   function automatic logic [31:0] fwd_col(input logic [31:0] col);
      logic [7:0] a  [4];
      logic [7:0] m2 [4];
      logic [31:0] r;
      for (int j = 0; j < 4; j++) begin
         a[j]  = col[31 - 8*j -: 8];
         m2[j] = xt(a[j]);
      end
      for (int i = 0; i < 4; i++) begin
         r[31 - 8*i -: 8] = m2[i] ^ m2[(i + 1) % 4] ^ a[(i + 1) % 4] ^ a[(i + 2) % 4] ^ a[(i + 3) % 4];
      end
      return r;
   endfunction
`endif

   always_comb begin
      for (int l = 0; l < COLS_PER_CYCLE; l++) begin
         lane_in[l] = col_of(work, cnt | 2'(l));
`ifdef MIXCOL_FWD_EN
         lane_out[l] = mode_q ? inv_col(lane_in[l]) : fwd_col(lane_in[l]);
`else
         lane_out[l] = inv_col(lane_in[l]);
`endif
      end
   end

   always_comb begin
      work_nxt = work;
      for (int c = 0; c < 4; c++) begin
         if ((2'(c) & MASK) == cnt) begin
            work_nxt[127 - 32*c -: 32] = lane_out[c % COLS_PER_CYCLE];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == LAST) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         work  <= '0;
         cnt   <= 2'd0;
`ifdef MIXCOL_FWD_EN
         mode_q <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (state == IDLE && bus.in_valid) begin
            work <= bus.state_in;
            cnt  <= 2'd0;
`ifdef MIXCOL_FWD_EN
            mode_q <= bus.mode;
`endif
         end else if (state == RUN) begin
            work <= work_nxt;
            cnt  <= cnt + STEP;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.busy      = busy;
   assign bus.state_out = work;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: three instances (1, 2, 4 columns/cycle) share stimulus; a GF(2^8) matrix model checks every cycle.
module tb_mix_columns_engine;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         mode = 1'b0;
   logic [127:0] state_in = '0;
   logic         out_ready = 1'b0;

   int n_checks = 0;
   int n_err    = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   mix_columns_engine_if u_if1 ();
   mix_columns_engine_if u_if2 ();
   mix_columns_engine_if u_if4 ();

   assign u_if1.in_valid = in_valid;  assign u_if2.in_valid = in_valid;  assign u_if4.in_valid = in_valid;
   assign u_if1.mode = mode;          assign u_if2.mode = mode;          assign u_if4.mode = mode;
   assign u_if1.state_in = state_in;  assign u_if2.state_in = state_in;  assign u_if4.state_in = state_in;
   assign u_if1.out_ready = out_ready; assign u_if2.out_ready = out_ready; assign u_if4.out_ready = out_ready;

   mix_columns_engine #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1));
   mix_columns_engine #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(u_if2));
   mix_columns_engine #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(u_if4));

   logic         ir [3];
   logic         ov [3];
   logic         bz [3];
   logic [127:0] so [3];
   assign ir[0] = u_if1.in_ready;  assign ir[1] = u_if2.in_ready;  assign ir[2] = u_if4.in_ready;
   assign ov[0] = u_if1.out_valid; assign ov[1] = u_if2.out_valid; assign ov[2] = u_if4.out_valid;
   assign bz[0] = u_if1.busy;      assign bz[1] = u_if2.busy;      assign bz[2] = u_if4.busy;
   assign so[0] = u_if1.state_out; assign so[1] = u_if2.state_out; assign so[2] = u_if4.state_out;

   localparam int LAT [3] = '{4, 2, 1};

   // ---------------- reference arithmetic ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic       hi;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         hi = x[7];
         x  = {x[6:0], 1'b0} ^ (hi ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [127:0] mix_state(input logic [127:0] s, input logic [31:0] coef);
      logic [127:0] r;
      logic [7:0]   acc;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(coef[31 - 8*((j - row + 4) % 4) -: 8], s[127 - 32*c - 8*j -: 8]);
            r[127 - 32*c - 8*row -: 8] = acc;
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] fwd_state(input logic [127:0] s);
      return mix_state(s, 32'h02030101);
   endfunction

   function automatic logic [127:0] inv_state(input logic [127:0] s);
      return mix_state(s, 32'h0e0b0d09);
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_checks++;
      n_err++;
      $display("FAIL timeout waiting for %s", nm);
   endtask

   // ---------------- transaction-level model ----------------
   logic         m_busy [3] = '{1'b0, 1'b0, 1'b0};
   int           m_rem  [3] = '{0, 0, 0};
   logic         m_ov   [3] = '{1'b0, 1'b0, 1'b0};
   logic [127:0] m_out  [3];
   logic [127:0] m_pend [3];

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            m_busy[k] = 1'b0;
            m_rem[k]  = 0;
            m_ov[k]   = 1'b0;
         end else if (!m_busy[k]) begin
            if (in_valid) begin
               m_busy[k] = 1'b1;
               m_rem[k]  = LAT[k];
`ifdef MIXCOL_FWD_EN
               m_pend[k] = mode ? inv_state(state_in) : fwd_state(state_in);
`else
               m_pend[k] = inv_state(state_in);
`endif
            end
         end else if (m_rem[k] > 0) begin
            m_rem[k]--;
            if (m_rem[k] == 0) begin
               m_ov[k]  = 1'b1;
               m_out[k] = m_pend[k];
            end
         end else if (out_ready) begin
            m_ov[k]   = 1'b0;
            m_busy[k] = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("in_ready[%0d]", k), 128'(ir[k]), 128'(!m_busy[k]));
            chk($sformatf("busy[%0d]", k), 128'(bz[k]), 128'(m_busy[k]));
            chk($sformatf("out_valid[%0d]", k), 128'(ov[k]), 128'(m_ov[k]));
            if (m_ov[k]) chk($sformatf("state_out[%0d]", k), so[k], m_out[k]);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [127:0] s, input logic m);
      int t = 0;
      while (!(ir[0] && ir[1] && ir[2]) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) timeout("in_ready");
      in_valid = 1'b1;
      state_in = s;
      mode     = m;
      @(negedge clk);
      in_valid = 1'b0;
      state_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      mode     = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_all_valid();
      int t = 0;
      while (!(ov[0] && ov[1] && ov[2]) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) timeout("out_valid");
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic chk_all_out(input string nm, input logic [127:0] exp);
      for (int k = 0; k < 3; k++) chk($sformatf("%s[%0d]", nm, k), so[k], exp);
   endtask

   logic [127:0] x, y;
   int           saw_ov;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      @(negedge clk);
      chk_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst in_ready[%0d]", k), 128'(ir[k]), 128'(1'b1));
         chk($sformatf("rst out_valid[%0d]", k), 128'(ov[k]), 128'(1'b0));
         chk($sformatf("rst busy[%0d]", k), 128'(bz[k]), 128'(1'b0));
         chk($sformatf("rst state_out[%0d]", k), so[k], 128'h0);
      end
      rst = 1'b0;
      @(negedge clk);

      // pin the reference model to known vectors
      chk("model fwd", fwd_state(128'hdb135345_f20a225c_01010101_2d26314c),
          128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
      chk("model inv", inv_state(128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6),
          128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5);

`ifdef MIXCOL_FWD_EN
      send(128'hdb135345_f20a225c_01010101_2d26314c, 1'b0);
      wait_all_valid();
      chk_all_out("fwd vec", 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
      release_out();
`endif

      // inverse vector, then hold the result under backpressure with a stray input pulse
      send(128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6, 1'b1);
      wait_all_valid();
      chk_all_out("inv vec", 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5);
      for (int i = 0; i < 10; i++) begin
         in_valid = (i == 3);
         state_in = 128'h01020304_05060708_090a0b0c_0d0e0f10;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk_all_out("held out", 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5);
      release_out();
      for (int k = 0; k < 3; k++) chk($sformatf("idle after drain[%0d]", k), 128'(ir[k]), 128'(1'b1));

      // second block: inverse applied (mode=0 in inverse-only builds must still invert)
`ifdef MIXCOL_FWD_EN
      send({4{32'h8e4da1bc}}, 1'b1);
`else
      send({4{32'h8e4da1bc}}, 1'b0);
`endif
      wait_all_valid();
      chk_all_out("second blk", {4{32'hdb135345}});
      release_out();

      // reset during the 2nd RUN cycle of the single-column engine
      send({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("abort in_ready[%0d]", k), 128'(ir[k]), 128'(1'b1));
         chk($sformatf("abort out_valid[%0d]", k), 128'(ov[k]), 128'(1'b0));
         chk($sformatf("abort busy[%0d]", k), 128'(bz[k]), 128'(1'b0));
         chk($sformatf("abort state_out[%0d]", k), so[k], 128'h0);
      end
      out_ready = 1'b1;
      saw_ov = 0;
      for (int i = 0; i < 8; i++) begin
         if (ov[0] || ov[1] || ov[2]) saw_ov++;
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk("aborted block output", 128'(saw_ov), 128'h0);

      // round trip on random states
      for (int n = 0; n < 100; n++) begin
         x = {$urandom(), $urandom(), $urandom(), $urandom()};
`ifdef MIXCOL_FWD_EN
         send(x, 1'b0);
         wait_all_valid();
         y = so[1];
         release_out();
         send(y, 1'b1);
`else
         y = fwd_state(x);
         send(y, 1'($urandom_range(0, 1)));
`endif
         wait_all_valid();
         chk_all_out("round trip", x);
         release_out();
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
